// File: rtl/lb_resp_pkg.sv
// Shared types and helpers for the golden line-buffer responder.
// Holds the FSM state encoding, the depth-port width and the depth clamp.
package lb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } lb_state_t;

  localparam int DEPTH_IN_W = 16;
  localparam int CLAMP_W    = DEPTH_IN_W + 1;

  // A requested depth of 0 behaves as 1; anything beyond capacity saturates.
  function automatic logic [CLAMP_W-1:0] lb_clamp_depth(
    input logic [DEPTH_IN_W-1:0] depth,
    input logic [CLAMP_W-1:0]    max_depth
  );
    logic [CLAMP_W-1:0] d;
    d = {1'b0, depth};
    if (d == '0)
      lb_clamp_depth = CLAMP_W'(1);
    else if (d > max_depth)
      lb_clamp_depth = max_depth;
    else
      lb_clamp_depth = d;
  endfunction

endpackage

// File: rtl/lb_resp_ram.sv
// Line-buffer storage: one write port, one registered read port, read-before-write.
// Read data appears one cycle after i_rd_en and holds otherwise; no backpressure.
module lb_resp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_dat
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem[i_wr_addr] <= i_wr_dat;
  end

  // Sampling the old array value gives read-before-write on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rd_dat <= '0;
    else if (i_rd_en)
      r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/lb_golden_responder.sv
// Golden line buffer: each push is returned exactly depth_l pushes later, one cycle after the popping push.
// No backpressure: pushes in STREAM without ren_in are dropped (flagged when LB_RESP_OVERFLOW_CHECK_EN is defined).
module lb_golden_responder
  import lb_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 64,
  parameter int AC_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [15:0]           depth,
  input  logic [AC_WIDTH-1:0]   almost_count,
  input  logic                  wen_in,
  input  logic                  ren_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef LB_RESP_OVERFLOW_CHECK_EN
  , output logic                overflow_err
`endif
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int CW = AW + 1;

  lb_state_t       r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CW-1:0]   r_depth_l, w_depth_l_nxt, w_depth_clamped;
  logic            r_valid;
  logic            w_wr_en, w_rd_en, w_drop;
  logic [31:0]     w_cnt32, w_dep32, w_ac32, w_af_thr;

  assign w_depth_clamped = CW'(lb_clamp_depth(depth, CLAMP_W'(MAX_DEPTH)));
  assign w_cnt_inc       = r_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_depth_l_nxt = r_depth_l;
    w_wr_en       = 1'b0;
    w_rd_en       = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (wen_in) begin
          w_depth_l_nxt = w_depth_clamped;
          w_wr_en       = 1'b1;
          w_cnt_nxt     = w_cnt_inc;
          w_state_nxt   = (w_depth_clamped == CW'(1)) ? STREAM : FILL;
        end
      end
      FILL: begin
        if (wen_in) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_depth_l)
            w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (wen_in) begin
          if (ren_in) begin
            w_wr_en = 1'b1;
            w_rd_en = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      w_drop      = 1'b0;
    end
    // clk_en low overrides everything, including flush.
    if (!clk_en) begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_depth_l_nxt = r_depth_l;
      w_wr_en       = 1'b0;
      w_rd_en       = 1'b0;
      w_drop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_depth_l <= CW'(1);
      r_valid   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_depth_l <= w_depth_l_nxt;
      r_valid   <= w_rd_en;
      if (clk_en && flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_en)
          r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd_en)
          r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  lb_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (data_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (data_out)
  );

  assign valid_out = r_valid;

  // Flags treat depth_l as 1 while idle so an empty buffer never looks full.
  assign w_cnt32  = 32'(r_cnt);
  assign w_dep32  = (r_state == IDLE) ? 32'd1 : 32'(r_depth_l);
  assign w_ac32   = 32'(almost_count);
  assign w_af_thr = (w_dep32 > w_ac32) ? (w_dep32 - w_ac32) : 32'd0;

  assign full         = (w_cnt32 == w_dep32);
  assign empty        = (r_cnt == '0);
  assign almost_full  = (w_cnt32 >= w_af_thr);
  assign almost_empty = (w_cnt32 <= w_ac32);

`ifdef LB_RESP_OVERFLOW_CHECK_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ovf <= 1'b0;
    else if (clk_en && flush)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
  end

  assign overflow_err = r_ovf;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !$rose(r_ovf));
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_lb_golden_responder.sv
// Bench for lb_golden_responder: constant vector table, hand sequences, and random traffic vs a queue model.
module tb_lb_golden_responder;

  localparam int DW   = 16;
  localparam int MAXD = 64;
  localparam int ACW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic [15:0]   depth;
  logic [ACW-1:0] almost_count;
  logic          wen_in;
  logic          ren_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
`ifdef LB_RESP_OVERFLOW_CHECK_EN
  logic          overflow_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  lb_golden_responder #(
    .DATA_WIDTH (DW),
    .MAX_DEPTH  (MAXD),
    .AC_WIDTH   (ACW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .flush        (flush),
    .depth        (depth),
    .almost_count (almost_count),
    .wen_in       (wen_in),
    .ren_in       (ren_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef LB_RESP_OVERFLOW_CHECK_EN
    , .overflow_err (overflow_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of words plus the latched delay.
  logic [DW-1:0] m_q[$];
  int            m_dl;
  bit            m_idle;
  bit            m_valid;
  logic [DW-1:0] m_dout;
  bit            m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_dl    = 1;
    m_idle  = 1;
    m_valid = 0;
    m_dout  = '0;
    m_ovf   = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    if (!clk_en) begin
      m_valid = 0;
      return;
    end
    if (flush) begin
      m_q.delete();
      m_idle  = 1;
      m_valid = 0;
      m_ovf   = 0;
      return;
    end
    m_valid = 0;
    if (wen_in) begin
      if (m_idle) begin
        m_dl   = (depth == 0) ? 1 : ((int'(depth) > MAXD) ? MAXD : int'(depth));
        m_idle = 0;
        m_q.push_back(data_in);
      end else if (m_q.size() < m_dl) begin
        m_q.push_back(data_in);
      end else if (ren_in) begin
        m_dout  = m_q.pop_front();
        m_valid = 1;
        m_q.push_back(data_in);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int cnt, dlf, thr;
    cnt = m_q.size();
    dlf = m_idle ? 1 : m_dl;
    thr = (dlf > int'(almost_count)) ? dlf - int'(almost_count) : 0;
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".data"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".full"}, 32'(full), 32'(cnt == dlf));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(cnt >= thr));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= int'(almost_count)));
`ifdef LB_RESP_OVERFLOW_CHECK_EN
    chk({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
`endif
  endtask

  // One rising edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic fl, input logic ce,
                       input logic [15:0] d, input logic [DW-1:0] din);
    wen_in  = w;
    ren_in  = r;
    flush   = fl;
    clk_en  = ce;
    depth   = d;
    data_in = din;
  endtask

  typedef struct {
    logic          wen, ren, fl, ce;
    logic [15:0]   dep;
    logic [DW-1:0] din;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ef, ee;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic w, input logic r, input logic fl, input logic ce,
                              input logic [15:0] d, input logic [DW-1:0] din,
                              input logic ev, input logic [DW-1:0] ed,
                              input logic ef, input logic ee);
    vec_t v;
    v.wen = w; v.ren = r; v.fl = fl; v.ce = ce; v.dep = d; v.din = din;
    v.ev = ev; v.ed = ed; v.ef = ef; v.ee = ee;
    return v;
  endfunction

  initial begin
    int st;
    model_reset();
    reset        = 1'b0;
    almost_count = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, '0);

    repeat (2) cycle();
    chk("rst.valid", 32'(valid_out), 32'd0);
    chk("rst.data", 32'(data_out), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.aempty", 32'(almost_empty), 32'd1);
    chk("rst.afull", 32'(almost_full), 32'd0);
    reset = 1'b1;

    tv.push_back(mk(1, 1, 0, 1, 16'd3, 16'h11, 0, 16'h00, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd3, 16'h22, 0, 16'h00, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd3, 16'h33, 0, 16'h00, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd3, 16'h44, 1, 16'h11, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd3, 16'h55, 1, 16'h22, 1, 0));
    tv.push_back(mk(0, 1, 0, 1, 16'd3, 16'h66, 0, 16'h22, 1, 0));
    tv.push_back(mk(1, 1, 1, 1, 16'd3, 16'h77, 0, 16'h22, 0, 1));
    tv.push_back(mk(1, 1, 0, 1, 16'd2, 16'hA0, 0, 16'h22, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd9, 16'hA1, 0, 16'h22, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd9, 16'hA2, 1, 16'hA0, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 16'd9, 16'hA3, 0, 16'hA0, 1, 0));
    tv.push_back(mk(0, 1, 0, 1, 16'd9, 16'hB0, 0, 16'hA0, 1, 0));
    tv.push_back(mk(1, 1, 0, 0, 16'd9, 16'hA4, 0, 16'hA0, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd9, 16'hA4, 1, 16'hA1, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 16'd9, 16'hA5, 1, 16'hA2, 1, 0));

    foreach (tv[i]) begin
      drive(tv[i].wen, tv[i].ren, tv[i].fl, tv[i].ce, tv[i].dep, tv[i].din);
      cycle();
      chk($sformatf("tv%0d.valid", i), 32'(valid_out), 32'(tv[i].ev));
      chk($sformatf("tv%0d.data", i), 32'(data_out), 32'(tv[i].ed));
      chk($sformatf("tv%0d.full", i), 32'(full), 32'(tv[i].ef));
      chk($sformatf("tv%0d.empty", i), 32'(empty), 32'(tv[i].ee));
    end

    // depth 1: every push returns the previous word on the next cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'd1, '0);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'd1, DW'(k));
      cycle();
      chk($sformatf("d1.valid%0d", k), 32'(valid_out), (k > 1) ? 32'd1 : 32'd0);
      if (k > 1) chk($sformatf("d1.data%0d", k), 32'(data_out), 32'(k - 1));
    end

    // Full-capacity delay across two pointer wraps.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'd64, '0);
    cycle();
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'd64, DW'(k + 16'h100));
      cycle();
      if (k == 63 || k == 64 || k == 127 || k == 128 || k == 199)
        chk($sformatf("d64.valid%0d", k), 32'(valid_out), (k >= 64) ? 32'd1 : 32'd0);
      if (k >= 64 && data_out !== DW'(k - 64 + 16'h100))
        chk($sformatf("d64.data%0d", k), 32'(data_out), 32'(k - 64 + 16'h100));
    end
    chk("d64.final", 32'(data_out), 32'(199 - 64 + 16'h100));

    // Clock-enable stall mid-stream, then resume.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'd4, '0);
    cycle();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'd4, DW'(k));
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'hEE);
      cycle();
      chk($sformatf("ce.valid%0d", k), 32'(valid_out), 32'd0);
      chk($sformatf("ce.full%0d", k), 32'(full), 32'd1);
      chk($sformatf("ce.data%0d", k), 32'(data_out), 32'd2);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'd4, 16'd7);
    cycle();
    chk("ce.resume_valid", 32'(valid_out), 32'd1);
    chk("ce.resume_data", 32'(data_out), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 16'hAA);
    cycle();
    chk_model("drop");
    chk("drop.valid", 32'(valid_out), 32'd0);

    // Asynchronous reset between edges clears outputs at once.
    #2;
    reset = 1'b0;
    #1;
    chk("arst.valid", 32'(valid_out), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.data", 32'(data_out), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, '0);
    cycle();
    reset = 1'b1;
    chk_model("arst");

    // Random traffic against the queue model.
    for (int n = 0; n < 2500; n++) begin
      st = int'($urandom_range(0, 99));
      wen_in       = ($urandom_range(0, 99) < 75);
      ren_in       = ($urandom_range(0, 99) < 80);
      flush        = (st < 2);
      clk_en       = ($urandom_range(0, 99) < 90);
      depth        = (st < 90) ? 16'($urandom_range(0, 12)) : 16'($urandom_range(13, 80));
      almost_count = ACW'($urandom_range(0, 15));
      data_in      = DW'($urandom);
      cycle();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
